// File: rtl/wb_spi_arbiter_if.sv
// Wishbone bundle between two masters, the arbiter and the SPI controller slave port.
// Modport slave is the arbiter's view of the bundle; modport master is the environment's view.
interface wb_spi_arbiter_if #(
    parameter int ADR_W = 8,
    parameter int DAT_W = 32
);
    logic [ADR_W-1:0] M0_ADR_I;
    logic [DAT_W-1:0] M0_DAT_I;
    logic             M0_WE_I;
    logic             M0_CYC_I;
    logic             M0_STB_I;
    logic [DAT_W-1:0] M0_DAT_O;
    logic             M0_ACK_O;
    logic             M0_ERR_O;

    logic [ADR_W-1:0] M1_ADR_I;
    logic [DAT_W-1:0] M1_DAT_I;
    logic             M1_WE_I;
    logic             M1_CYC_I;
    logic             M1_STB_I;
    logic [DAT_W-1:0] M1_DAT_O;
    logic             M1_ACK_O;
    logic             M1_ERR_O;

    logic [ADR_W-1:0] S_ADR_O;
    logic [DAT_W-1:0] S_DAT_O;
    logic             S_WE_O;
    logic             S_CYC_O;
    logic             S_STB_O;
    logic [DAT_W-1:0] S_DAT_I;
    logic             S_ACK_I;

    modport slave (
        input  M0_ADR_I, M0_DAT_I, M0_WE_I, M0_CYC_I, M0_STB_I,
        output M0_DAT_O, M0_ACK_O, M0_ERR_O,
        input  M1_ADR_I, M1_DAT_I, M1_WE_I, M1_CYC_I, M1_STB_I,
        output M1_DAT_O, M1_ACK_O, M1_ERR_O,
        output S_ADR_O, S_DAT_O, S_WE_O, S_CYC_O, S_STB_O,
        input  S_DAT_I, S_ACK_I
    );

    modport master (
        output M0_ADR_I, M0_DAT_I, M0_WE_I, M0_CYC_I, M0_STB_I,
        input  M0_DAT_O, M0_ACK_O, M0_ERR_O,
        output M1_ADR_I, M1_DAT_I, M1_WE_I, M1_CYC_I, M1_STB_I,
        input  M1_DAT_O, M1_ACK_O, M1_ERR_O,
        input  S_ADR_O, S_DAT_O, S_WE_O, S_CYC_O, S_STB_O,
        output S_DAT_I, S_ACK_I
    );
endinterface

// File: rtl/wb_spi_arbiter.sv
// Round-robin, cycle-locked two-master Wishbone arbiter in front of the SPI EEPROM controller.
// Optional stall watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_spi_arbiter #(
    parameter int ADR_W          = 8,
    parameter int DAT_W          = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic               CLK_I,
    input  logic               RST_I,
    wb_spi_arbiter_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t state_r;
    logic   last_r;
    logic   gnt_cyc_s;
    logic   gnt_stb_s;
    logic   abort_s;

    // The watchdog counter needs a limit of at least 2 to be meaningful.
    if (TIMEOUT_CYCLES < 2) begin : g_timeout_too_small
    end

    // CYC/STB of whichever master currently holds the grant.
    always_comb begin
        gnt_cyc_s = 1'b0;
        gnt_stb_s = 1'b0;
        case (state_r)
            GNT0: begin
                gnt_cyc_s = bus.M0_CYC_I;
                gnt_stb_s = bus.M0_STB_I;
            end
            GNT1: begin
                gnt_cyc_s = bus.M1_CYC_I;
                gnt_stb_s = bus.M1_STB_I;
            end
            default: begin
                gnt_cyc_s = 1'b0;
                gnt_stb_s = 1'b0;
            end
        endcase
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_r;
    logic             abort_r;
    logic             to_hit_s;

    assign to_hit_s = gnt_cyc_s & gnt_stb_s & ~bus.S_ACK_I & ~abort_r & (cnt_r == CNT_MAX);
    assign abort_s  = abort_r;
`else
    assign abort_s  = 1'b0;
`endif

    // Arbitration FSM, round-robin pointer and (optionally) the stall watchdog.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_r <= IDLE;
            last_r  <= 1'b1;
`ifdef WB_ARB_TIMEOUT_EN
            cnt_r   <= '0;
            abort_r <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.M0_CYC_I && bus.M1_CYC_I) begin
                        state_r <= last_r ? GNT0 : GNT1;
                    end else if (bus.M0_CYC_I) begin
                        state_r <= GNT0;
                    end else if (bus.M1_CYC_I) begin
                        state_r <= GNT1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                GNT0: begin
                    if (!bus.M0_CYC_I) begin
                        last_r  <= 1'b0;
                        state_r <= bus.M1_CYC_I ? GNT1 : IDLE;
                    end else begin
                        state_r <= GNT0;
                    end
                end
                GNT1: begin
                    if (!bus.M1_CYC_I) begin
                        last_r  <= 1'b1;
                        state_r <= bus.M0_CYC_I ? GNT0 : IDLE;
                    end else begin
                        state_r <= GNT1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
`ifdef WB_ARB_TIMEOUT_EN
            // A dropped granted CYC covers idle, release and handoff, so each grant starts at zero.
            if (!gnt_cyc_s) begin
                cnt_r   <= '0;
                abort_r <= 1'b0;
            end else if (bus.S_ACK_I) begin
                cnt_r   <= '0;
            end else if (to_hit_s) begin
                abort_r <= 1'b1;
            end else if (gnt_stb_s && !abort_r) begin
                cnt_r   <= cnt_r + CNT_W'(1);
            end else begin
                cnt_r   <= cnt_r;
            end
`endif
        end
    end

    // Slave-side request mux and master-side response routing.
    always_comb begin
        bus.S_ADR_O  = {ADR_W{1'b0}};
        bus.S_DAT_O  = {DAT_W{1'b0}};
        bus.S_WE_O   = 1'b0;
        bus.M0_ACK_O = 1'b0;
        bus.M1_ACK_O = 1'b0;
        bus.M0_DAT_O = bus.S_DAT_I;
        bus.M1_DAT_O = bus.S_DAT_I;
        case (state_r)
            GNT0: begin
                bus.S_ADR_O  = bus.M0_ADR_I;
                bus.S_DAT_O  = bus.M0_DAT_I;
                bus.S_WE_O   = bus.M0_WE_I;
                bus.M0_ACK_O = bus.S_ACK_I;
            end
            GNT1: begin
                bus.S_ADR_O  = bus.M1_ADR_I;
                bus.S_DAT_O  = bus.M1_DAT_I;
                bus.S_WE_O   = bus.M1_WE_I;
                bus.M1_ACK_O = bus.S_ACK_I;
            end
            default: begin
                bus.S_ADR_O  = {ADR_W{1'b0}};
                bus.S_DAT_O  = {DAT_W{1'b0}};
                bus.S_WE_O   = 1'b0;
            end
        endcase
    end

    assign bus.S_CYC_O = gnt_cyc_s & ~abort_s;
    assign bus.S_STB_O = gnt_stb_s & ~abort_s;

`ifdef WB_ARB_TIMEOUT_EN
    assign bus.M0_ERR_O = to_hit_s & (state_r == GNT0);
    assign bus.M1_ERR_O = to_hit_s & (state_r == GNT1);
`else
    assign bus.M0_ERR_O = 1'b0;
    assign bus.M1_ERR_O = 1'b0;
`endif

endmodule

// File: tb/tb_wb_spi_arbiter.sv
// Self-checking bench for wb_spi_arbiter: scoreboard of expected acks plus per-scenario inline checks.
// Follows WB_ARB_TIMEOUT_EN when choosing the timeout expectations.
module tb_wb_spi_arbiter;

    logic CLK_I = 1'b0;
    logic RST_I;

    wb_spi_arbiter_if #(.ADR_W(8), .DAT_W(32)) bus ();

    wb_spi_arbiter #(.ADR_W(8), .DAT_W(32), .TIMEOUT_CYCLES(16)) dut (
        .CLK_I (CLK_I),
        .RST_I (RST_I),
        .bus   (bus)
    );

    always #5 CLK_I = ~CLK_I;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int          m;
        logic [31:0] d;
    } exp_t;
    exp_t sb_q[$];

    bit          mon_en     = 1'b0;
    bit          slave_en   = 1'b1;
    bit          dat_ovr_en = 1'b0;
    logic [31:0] dat_ovr    = 32'h0000_0000;
    logic        s_ack      = 1'b0;
    logic [31:0] slave_dat  = 32'h0000_0000;

    assign bus.S_ACK_I = s_ack;
    assign bus.S_DAT_I = dat_ovr_en ? dat_ovr : slave_dat;

    function automatic logic [31:0] rd_word(input logic [7:0] a);
        return {8'hD0, a, ~a, 8'h3C};
    endfunction

    // Slave model: registered single-cycle ack, read data derived from the address.
    always @(posedge CLK_I) begin
        if (RST_I) begin
            s_ack <= 1'b0;
        end else if (bus.S_CYC_O && bus.S_STB_O && !s_ack && slave_en) begin
            s_ack     <= 1'b1;
            slave_dat <= rd_word(bus.S_ADR_O);
        end else begin
            s_ack <= 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic m_set(input int m, input bit cyc, input logic [7:0] a, input logic [31:0] d, input bit we);
        if (m == 0) begin
            bus.M0_CYC_I = cyc; bus.M0_STB_I = cyc; bus.M0_ADR_I = a; bus.M0_DAT_I = d; bus.M0_WE_I = we;
        end else begin
            bus.M1_CYC_I = cyc; bus.M1_STB_I = cyc; bus.M1_ADR_I = a; bus.M1_DAT_I = d; bus.M1_WE_I = we;
        end
    endtask

    task automatic m_idle(input int m);
        m_set(m, 1'b0, 8'h00, 32'h0000_0000, 1'b0);
    endtask

    task automatic push(input int m, input logic [7:0] a);
        exp_t e;
        e.m = m;
        e.d = rd_word(a);
        sb_q.push_back(e);
    endtask

    task automatic wait_ack(input int m);
        bit seen = 1'b0;
        for (int i = 0; i < 64 && !seen; i++) begin
            @(negedge CLK_I);
            seen = (m == 0) ? bus.M0_ACK_O : bus.M1_ACK_O;
        end
        checks++;
        if (seen !== 1'b1) begin
            failures++;
            $display("FAIL ack_wait_m%0d: ack=0 required=1 within 64 cycles", m);
        end
    endtask

    task automatic do_reset();
        @(posedge CLK_I); #1;
        RST_I = 1'b1;
        m_idle(0);
        m_idle(1);
        @(posedge CLK_I); #1;
        RST_I = 1'b0;
    endtask

    // Pops the scoreboard on every master ack and checks routing and data.
    task automatic monitor();
        forever begin
            @(negedge CLK_I);
            if (mon_en && (bus.M0_ACK_O || bus.M1_ACK_O)) begin
                exp_t        e;
                int          got_m;
                logic [31:0] got_d;
                got_m = bus.M1_ACK_O ? 1 : 0;
                got_d = (got_m == 1) ? bus.M1_DAT_O : bus.M0_DAT_O;
                checks++;
                if (bus.M0_ACK_O && bus.M1_ACK_O) begin
                    failures++;
                    $display("FAIL sb_dual_ack: both ACKs high at %0t", $time);
                end else if (sb_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected: ack from m%0d data=%h with empty scoreboard", got_m, got_d);
                end else begin
                    e = sb_q.pop_front();
                    if (got_m !== e.m || got_d !== e.d) begin
                        failures++;
                        $display("FAIL sb_ack: got m%0d data=%h required m%0d data=%h", got_m, got_d, e.m, e.d);
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        dat_ovr    = 32'hCAFE_F00D;
        dat_ovr_en = 1'b1;
        @(posedge CLK_I); #1;
        RST_I = 1'b1;
        m_set(0, 1'b1, 8'h01, 32'h1111_1111, 1'b1);
        m_set(1, 1'b1, 8'h02, 32'h2222_2222, 1'b1);
        repeat (2) @(posedge CLK_I);
        @(negedge CLK_I);
        checks++;
        if ({bus.S_CYC_O, bus.S_STB_O, bus.S_WE_O} !== 3'b000) begin
            failures++;
            $display("FAIL reset_s_ctrl: cyc/stb/we=%b required 000", {bus.S_CYC_O, bus.S_STB_O, bus.S_WE_O});
        end
        checks++;
        if (bus.S_ADR_O !== 8'h00 || bus.S_DAT_O !== 32'h0000_0000) begin
            failures++;
            $display("FAIL reset_s_bus: adr=%h dat=%h required 0", bus.S_ADR_O, bus.S_DAT_O);
        end
        checks++;
        if ({bus.M0_ACK_O, bus.M1_ACK_O, bus.M0_ERR_O, bus.M1_ERR_O} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_ack_err: ack/err=%b required 0000",
                     {bus.M0_ACK_O, bus.M1_ACK_O, bus.M0_ERR_O, bus.M1_ERR_O});
        end
        checks++;
        if (bus.M0_DAT_O !== 32'hCAFE_F00D || bus.M1_DAT_O !== 32'hCAFE_F00D) begin
            failures++;
            $display("FAIL reset_dat_o: m0=%h m1=%h required cafef00d", bus.M0_DAT_O, bus.M1_DAT_O);
        end
        @(posedge CLK_I); #1;
        RST_I = 1'b0;
        m_idle(0);
        m_idle(1);
        dat_ovr_en = 1'b0;
        mon_en     = 1'b1;
    endtask

    task automatic test_single();
        bit seen = 1'b0;
        do_reset();
        @(posedge CLK_I); #1;
        m_set(0, 1'b1, 8'h01, 32'h4154_A000, 1'b1);
        push(0, 8'h01);
        @(negedge CLK_I);
        checks++;
        if (bus.S_CYC_O !== 1'b0) begin
            failures++;
            $display("FAIL single_latency: S_CYC_O=%b required 0 in request cycle", bus.S_CYC_O);
        end
        @(negedge CLK_I);
        checks++;
        if ({bus.S_CYC_O, bus.S_STB_O, bus.S_WE_O} !== 3'b111 || bus.S_ADR_O !== 8'h01 ||
            bus.S_DAT_O !== 32'h4154_A000) begin
            failures++;
            $display("FAIL single_fwd: cyc/stb/we=%b adr=%h dat=%h required 111 01 4154a000",
                     {bus.S_CYC_O, bus.S_STB_O, bus.S_WE_O}, bus.S_ADR_O, bus.S_DAT_O);
        end
        for (int i = 0; i < 20 && !seen; i++) begin
            checks++;
            if (bus.M0_ACK_O !== bus.S_ACK_I || bus.M1_ACK_O !== 1'b0) begin
                failures++;
                $display("FAIL single_ack: m0_ack=%b s_ack=%b m1_ack=%b required m0=s_ack m1=0",
                         bus.M0_ACK_O, bus.S_ACK_I, bus.M1_ACK_O);
            end
            seen = bus.M0_ACK_O;
            if (!seen) @(negedge CLK_I);
        end
        checks++;
        if (seen !== 1'b1) begin
            failures++;
            $display("FAIL single_ack_seen: ack=0 required=1");
        end
        @(posedge CLK_I); #1;
        m_idle(0);
        repeat (2) @(posedge CLK_I);
    endtask

    task automatic test_tie();
        do_reset();
        @(posedge CLK_I); #1;
        m_set(0, 1'b1, 8'h01, 32'h0000_0000, 1'b0);
        m_set(1, 1'b1, 8'h02, 32'h0000_0000, 1'b0);
        push(0, 8'h01);
        push(1, 8'h02);
        @(negedge CLK_I);
        @(negedge CLK_I);
        checks++;
        if (bus.S_CYC_O !== 1'b1 || bus.S_ADR_O !== 8'h01) begin
            failures++;
            $display("FAIL tie_first: cyc=%b adr=%h required 1 01", bus.S_CYC_O, bus.S_ADR_O);
        end
        wait_ack(0);
        @(posedge CLK_I); #1;
        m_idle(0);
        @(posedge CLK_I);
        @(negedge CLK_I);
        checks++;
        if (bus.S_CYC_O !== 1'b1 || bus.S_ADR_O !== 8'h02) begin
            failures++;
            $display("FAIL tie_handoff: cyc=%b adr=%h required 1 02", bus.S_CYC_O, bus.S_ADR_O);
        end
        wait_ack(1);
        @(posedge CLK_I); #1;
        m_idle(1);
        repeat (2) @(posedge CLK_I);
    endtask

    task automatic test_round_robin();
        do_reset();
        push(0, 8'h04);
        push(1, 8'h02);
        push(0, 8'h04);
        push(1, 8'h02);
        @(posedge CLK_I); #1;
        fork
            for (int k = 0; k < 2; k++) begin
                m_set(0, 1'b1, 8'h04, 32'h0000_0000, 1'b0);
                wait_ack(0);
                @(posedge CLK_I); #1;
                m_idle(0);
                @(posedge CLK_I); #1;
            end
            for (int k = 0; k < 2; k++) begin
                m_set(1, 1'b1, 8'h02, 32'h0000_0000, 1'b0);
                wait_ack(1);
                @(posedge CLK_I); #1;
                m_idle(1);
                @(posedge CLK_I); #1;
            end
        join
        repeat (2) @(posedge CLK_I);
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL rr_drain: %0d expected acks left, required 0", sb_q.size());
        end
    endtask

    task automatic test_lock();
        int acks = 0;
        do_reset();
        mon_en   = 1'b0;
        slave_en = 1'b1;
        @(posedge CLK_I); #1;
        m_set(1, 1'b1, 8'h03, 32'h0000_0000, 1'b0);
        @(posedge CLK_I); #1;
        for (int i = 0; i < 8; i++) begin
            m_set(0, i[0], 8'h01, 32'h0BAD_0BAD, 1'b1);
            @(negedge CLK_I);
            if (bus.S_ACK_I) acks++;
            checks++;
            if (bus.S_CYC_O !== 1'b1 || bus.S_ADR_O !== 8'h03 || bus.S_WE_O !== 1'b0 ||
                bus.S_DAT_O !== 32'h0000_0000 || bus.M0_ACK_O !== 1'b0 || bus.M1_ACK_O !== bus.S_ACK_I) begin
                failures++;
                $display("FAIL lock_hold: cyc=%b adr=%h we=%b dat=%h m0_ack=%b m1_ack=%b s_ack=%b required M1 fields",
                         bus.S_CYC_O, bus.S_ADR_O, bus.S_WE_O, bus.S_DAT_O, bus.M0_ACK_O, bus.M1_ACK_O, bus.S_ACK_I);
            end
            @(posedge CLK_I); #1;
        end
        checks++;
        if (acks < 2) begin
            failures++;
            $display("FAIL lock_acks: slave acks seen=%0d required >=2", acks);
        end
        RST_I = 1'b1;
        m_set(0, 1'b1, 8'h01, 32'h0BAD_0BAD, 1'b1);
        @(posedge CLK_I);
        @(negedge CLK_I);
        checks++;
        if (bus.S_CYC_O !== 1'b0 || bus.S_STB_O !== 1'b0 || bus.S_ADR_O !== 8'h00 || bus.M1_ACK_O !== 1'b0) begin
            failures++;
            $display("FAIL lock_reset: cyc=%b stb=%b adr=%h m1_ack=%b required 0 0 00 0",
                     bus.S_CYC_O, bus.S_STB_O, bus.S_ADR_O, bus.M1_ACK_O);
        end
        @(posedge CLK_I); #1;
        RST_I = 1'b0;
        m_idle(0);
        m_idle(1);
        repeat (2) @(posedge CLK_I);
        mon_en = 1'b1;
    endtask

    task automatic test_timeout();
        int err0 = 0;
        int err1 = 0;
        int err_at = 0;
        bit cyc15 = 1'b0;
        bit cyc_after = 1'b1;
        bit cyc40 = 1'b0;
        do_reset();
        slave_en = 1'b0;
        @(posedge CLK_I); #1;
        m_set(0, 1'b1, 8'h01, 32'h5EED_0001, 1'b1);
        @(posedge CLK_I); #1;
        m_set(1, 1'b1, 8'h02, 32'h0000_0000, 1'b0);
        push(1, 8'h02);
        for (int n = 1; n <= 40; n++) begin
            @(negedge CLK_I);
            if (bus.M0_ERR_O) begin
                err0++;
                err_at = n;
            end
            if (bus.M1_ERR_O) err1++;
            if (n == 15) cyc15 = bus.S_CYC_O;
            if (err_at != 0 && n == err_at + 1) cyc_after = bus.S_CYC_O | bus.S_STB_O;
            if (n == 40) cyc40 = bus.S_CYC_O;
        end
`ifdef WB_ARB_TIMEOUT_EN
        checks++;
        if (err0 != 1 || err_at != 16) begin
            failures++;
            $display("FAIL to_err_pulse: pulses=%0d at_cycle=%0d required 1 at 16", err0, err_at);
        end
        checks++;
        if (cyc15 !== 1'b1 || cyc_after !== 1'b0 || cyc40 !== 1'b0) begin
            failures++;
            $display("FAIL to_abort: cyc15=%b after=%b cyc40=%b required 1 0 0", cyc15, cyc_after, cyc40);
        end
`else
        checks++;
        if (err0 != 0) begin
            failures++;
            $display("FAIL to_no_err: pulses=%0d required 0", err0);
        end
        checks++;
        if (cyc15 !== 1'b1 || cyc40 !== 1'b1 || bus.S_ADR_O !== 8'h01) begin
            failures++;
            $display("FAIL to_stall: cyc15=%b cyc40=%b adr=%h required 1 1 01", cyc15, cyc40, bus.S_ADR_O);
        end
`endif
        checks++;
        if (err1 != 0) begin
            failures++;
            $display("FAIL to_m1_err: pulses=%0d required 0", err1);
        end
        @(posedge CLK_I); #1;
        m_idle(0);
        slave_en = 1'b1;
        wait_ack(1);
        @(posedge CLK_I); #1;
        m_idle(1);
        repeat (2) @(posedge CLK_I);
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL to_drain: %0d expected acks left, required 0", sb_q.size());
        end
    endtask

    initial begin
        RST_I = 1'b1;
        m_idle(0);
        m_idle(1);
        fork
            monitor();
        join_none
        test_reset();
        test_single();
        test_tie();
        test_round_robin();
        test_lock();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_spi_arbiter.md
Name: wb_spi_arbiter

Overview:
- Two-master Wishbone arbiter that shares the single Wishbone slave port of the SPI EEPROM controller (register addresses 1..4, 32-bit command words) between two requesters, e.g. a boot loader and a CPU.
- Grants are round-robin and cycle-locked: a grant is held until the granted master drops CYC.
- Sits between the masters and the SPI controller slave port; the SPI side is untouched.

Parameters:
- ADR_W, 8, address width.
- DAT_W, 32, data width.
- TIMEOUT_CYCLES, 1024, watchdog limit in cycles; used only with the optional feature.

Ports:
- CLK_I  in  1  system clock.
- RST_I  in  1  synchronous active-high reset.
- M0_ADR_I  in  ADR_W  master 0 address.
- M0_DAT_I  in  DAT_W  master 0 write data.
- M0_WE_I  in  1  master 0 write enable.
- M0_CYC_I  in  1  master 0 cycle.
- M0_STB_I  in  1  master 0 strobe.
- M0_DAT_O  out  DAT_W  read data to master 0.
- M0_ACK_O  out  1  ack to master 0.
- M0_ERR_O  out  1  timeout error to master 0.
- M1_*  same set as M0_*, for master 1.
- S_ADR_O  out  ADR_W  address to SPI controller.
- S_DAT_O  out  DAT_W  write data to SPI controller.
- S_WE_O  out  1  write enable to SPI controller.
- S_CYC_O  out  1  cycle to SPI controller.
- S_STB_O  out  1  strobe to SPI controller.
- S_DAT_I  in  DAT_W  read data from SPI controller.
- S_ACK_I  in  1  ack from SPI controller.

Behaviour:
- Clock and reset: one clock, CLK_I; reset RST_I is synchronous and active-high.
- State machine: IDLE, GNT0, GNT1, plus a 1-bit round-robin pointer `last` (0 = M0 was served last).
- Reset, or RST_I seen at any clock edge, including mid-cycle:
  - state <= IDLE, last <= 1, so M0 wins the first tie.
  - All S_* outputs 0; all ACK/ERR outputs 0; DAT_O outputs follow S_DAT_I.
- IDLE, at a clock edge:
  - Only M0_CYC_I high -> GNT0.
  - Only M1_CYC_I high -> GNT1.
  - Both high -> grant the master not equal to `last`.
  - Neither high -> stay in IDLE.
  - Arbitration latency is 1 cycle: the slave sees the request one cycle after CYC rises.
- GNTx:
  - S_ADR_O/S_DAT_O/S_WE_O/S_STB_O are driven combinationally from master x.
  - S_CYC_O = Mx_CYC_I.
  - The non-granted master's STB is ignored and its ACK/ERR stay 0.
- Exit from GNTx, at a clock edge where Mx_CYC_I = 0:
  - last <= x.
  - If the other master's CYC is high -> go directly to that master's grant (no idle gap).
  - Otherwise -> IDLE.
- Grant is never taken while the granted CYC is high, whatever the other master does.
- Response routing:
  - Mx_ACK_O = S_ACK_I & (state == GNTx); it is combinational with zero added latency.
  - M0_DAT_O = M1_DAT_O = S_DAT_I.
- Outside IDLE/GNTx, S_CYC_O and S_STB_O are 0; S_ADR_O/S_DAT_O/S_WE_O are 0 in IDLE.
- Simultaneous events:
  - The granted master drops CYC on the same edge the other raises CYC -> handoff to the other master on that edge.
  - S_ACK_I arriving while in IDLE is ignored.

Optional Feature:
- Macro: WB_ARB_TIMEOUT_EN.
- With the macro:
  - A counter resets to 0 on grant entry and on every cycle with S_ACK_I = 1.
  - It increments each cycle in GNTx with Mx_STB_I = 1 and S_ACK_I = 0.
  - When the count reaches TIMEOUT_CYCLES-1, Mx_ERR_O pulses for exactly 1 cycle.
  - A sticky abort flag is then set; while it is set, S_CYC_O = S_STB_O = 0 until Mx_CYC_I drops.
  - Normal release then follows; the flag clears on exit and on reset.
- Without the macro: M0_ERR_O = M1_ERR_O = 0, and no counter or flag logic is present.

Test Plan:
- Reset/single master: after reset, M0 writes addr 1, data 0x4154A000. Expect S_CYC_O high from the cycle after M0_CYC_I rises, S_ADR_O = 1, S_DAT_O = 0x4154A000, and M0_ACK_O equal to S_ACK_I. M1_ACK_O stays 0 throughout.
- Tie: M0 and M1 raise CYC on the same edge out of reset. M0 is granted first. When M0 drops CYC, M1 is granted on the next edge, and S_ADR_O switches to M1's address (2) with no IDLE cycle.
- Round robin: M0 and M1 both request repeatedly with back-to-back cycles (M0 reads addr 4, M1 reads addr 2). Grants alternate 0,1,0,1, and each S_DAT_I value reaches the correct master's DAT_O qualified by its own ACK.
- Lock: during M1's grant, M0 toggles CYC/STB; S_* stays on M1 values, M0_ACK_O = 0. Assert RST_I mid-grant -> next edge state IDLE, S_CYC_O = 0.
- Timeout (WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 16): the slave never acks an M0 write. M0_ERR_O pulses once after 16 cycles of STB, and S_CYC_O/S_STB_O drop. M0 drops CYC, then a pending M1 request is granted.
- Timeout compiled out: the same stall stalls indefinitely and M0_ERR_O stays 0.
